// File: rtl/vga_pattern_module_pkg.sv
// Shared constants for the VGA pattern generator: default widths,
// pattern mode encodings and the stock 640x480@60 timing set.
package vga_pattern_module_pkg;

  localparam int D_WIDTH_DEF = 8;
  localparam int P_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_RECT  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Bars run white at the left down to black at the right.
  function automatic logic [2:0] bar_code(input logic [2:0] bar);
    return 3'd7 - bar;
  endfunction

endpackage

// File: rtl/vga_pattern_module_if.sv
// Configuration inputs and VGA pin outputs of the pattern generator.
// Free-running raster: no valid/ready flow control on either side.
interface vga_pattern_module_if #(
  parameter int D_WIDTH = 8,
  parameter int P_WIDTH = 12
);
  logic [1:0]         MODE;
  logic [D_WIDTH-1:0] Red;
  logic [D_WIDTH-1:0] Green;
  logic [D_WIDTH-1:0] Blue;
  logic [P_WIDTH-1:0] RECT_X0;
  logic [P_WIDTH-1:0] RECT_X1;
  logic [P_WIDTH-1:0] RECT_Y0;
  logic [P_WIDTH-1:0] RECT_Y1;
  logic [D_WIDTH-1:0] VGA_R;
  logic [D_WIDTH-1:0] VGA_G;
  logic [D_WIDTH-1:0] VGA_B;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_DE;
  logic               FRAME_START;
  logic [7:0]         FRAME_CNT;

  modport master (
    output MODE, Red, Green, Blue, RECT_X0, RECT_X1, RECT_Y0, RECT_Y1,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_START, FRAME_CNT
  );

  modport slave (
    input  MODE, Red, Green, Blue, RECT_X0, RECT_X1, RECT_Y0, RECT_Y1,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_START, FRAME_CNT
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters with active/sync decode and the last-pixel-of-frame strobe.
// Decoded outputs are combinational from the counters (stage 0).
module vga_timing_gen #(
  parameter int P_WIDTH  = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic               clk,
  input  logic               rst,
  output logic [P_WIDTH-1:0] h,
  output logic [P_WIDTH-1:0] v,
  output logic               active,
  output logic               hs_act,
  output logic               vs_act,
  output logic               frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [P_WIDTH-1:0] H_LAST = P_WIDTH'(H_TOTAL - 1);
  localparam logic [P_WIDTH-1:0] V_LAST = P_WIDTH'(V_TOTAL - 1);
  localparam logic [P_WIDTH-1:0] H_ACT  = P_WIDTH'(H_ACTIVE);
  localparam logic [P_WIDTH-1:0] V_ACT  = P_WIDTH'(V_ACTIVE);
  localparam logic [P_WIDTH-1:0] HS_BEG = P_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [P_WIDTH-1:0] HS_END = P_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [P_WIDTH-1:0] VS_BEG = P_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [P_WIDTH-1:0] VS_END = P_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + P_WIDTH'(1);
    end else begin
      h <= h + P_WIDTH'(1);
    end
  end

  assign active    = (h < H_ACT) && (v < V_ACT);
  assign hs_act    = (h >= HS_BEG) && (h < HS_END);
  assign vs_act    = (v >= VS_BEG) && (v < VS_END);
  assign frame_end = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/vga_pattern_module.sv
// Parametrised VGA raster with four per-frame patterns. Config is shadowed
// at the frame boundary; every output passes through two register stages.
module vga_pattern_module
  import vga_pattern_module_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int P_WIDTH    = P_WIDTH_DEF,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                 VGA_CLK,
  input  logic                 VGA_RST,
  vga_pattern_module_if.slave  bus
);

  localparam logic [P_WIDTH-1:0] BAR_W =
    P_WIDTH'((H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1);

  logic [P_WIDTH-1:0] h, v;
  logic               active, hs_act, vs_act, frame_end;

  vga_timing_gen #(
    .P_WIDTH (P_WIDTH),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk      (VGA_CLK),
    .rst      (VGA_RST),
    .h        (h),
    .v        (v),
    .active   (active),
    .hs_act   (hs_act),
    .vs_act   (vs_act),
    .frame_end(frame_end)
  );

  // Shadow config: captured on the last counter position of a frame so the
  // next frame sees one consistent set of values from its first pixel.
  mode_e              mode_s;
  logic [D_WIDTH-1:0] fg_r, fg_g, fg_b;
  logic [P_WIDTH-1:0] x0_s, x1_s, y0_s, y1_s;

  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST || frame_end) begin
      mode_s <= mode_e'(bus.MODE);
      fg_r   <= bus.Red;
      fg_g   <= bus.Green;
      fg_b   <= bus.Blue;
      x0_s   <= bus.RECT_X0;
      x1_s   <= bus.RECT_X1;
      y0_s   <= bus.RECT_Y0;
      y1_s   <= bus.RECT_Y1;
    end
  end

  logic [P_WIDTH-1:0] bar_idx;
  logic [2:0]         bar, code;
  logic               fg_on;
  logic [D_WIDTH-1:0] pr, pg, pb;

  always_comb begin
    bar_idx = h / BAR_W;
    bar     = (bar_idx > P_WIDTH'(7)) ? 3'd7 : bar_idx[2:0];
    code    = bar_code(bar);
    fg_on   = 1'b0;
    pr      = '0;
    pg      = '0;
    pb      = '0;
    unique case (mode_s)
      MODE_SOLID: fg_on = 1'b1;
      MODE_RECT:  fg_on = (h >= x0_s) && (h < x1_s) && (v >= y0_s) && (v < y1_s);
      MODE_BARS: begin
        pr = code[2] ? '1 : '0;
        pg = code[1] ? '1 : '0;
        pb = code[0] ? '1 : '0;
      end
      MODE_CHECK: fg_on = (h[CHECK_LOG2] ^ v[CHECK_LOG2]) == 1'b0;
    endcase
    if (fg_on) begin
      pr = fg_r;
      pg = fg_g;
      pb = fg_b;
    end
  end

  // Stage 1: decode and colour, blanked outside active video.
  logic               de1, hs1, vs1, fs1;
  logic [D_WIDTH-1:0] r1, g1, b1;
  logic               seen_first;

  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST) begin
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      fs1 <= 1'b0;
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
    end else begin
      de1 <= active;
      hs1 <= hs_act;
      vs1 <= vs_act;
      fs1 <= (h == '0) && (v == '0);
      r1  <= active ? pr : '0;
      g1  <= active ? pg : '0;
      b1  <= active ? pb : '0;
    end
  end

  // Stage 2: pin registers. The frame counter skips the first FRAME_START
  // after reset so it counts completed frames.
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST) begin
      bus.VGA_DE      <= 1'b0;
      bus.VGA_HS      <= ~HS_POL;
      bus.VGA_VS      <= ~VS_POL;
      bus.FRAME_START <= 1'b0;
      bus.VGA_R       <= '0;
      bus.VGA_G       <= '0;
      bus.VGA_B       <= '0;
      bus.FRAME_CNT   <= 8'd0;
      seen_first      <= 1'b0;
    end else begin
      bus.VGA_DE      <= de1;
      bus.VGA_HS      <= hs1 ? HS_POL : ~HS_POL;
      bus.VGA_VS      <= vs1 ? VS_POL : ~VS_POL;
      bus.FRAME_START <= fs1;
      bus.VGA_R       <= r1;
      bus.VGA_G       <= g1;
      bus.VGA_B       <= b1;
      if (fs1) begin
        if (seen_first) bus.FRAME_CNT <= bus.FRAME_CNT + 8'd1;
        seen_first <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_module.sv
// Directed bench for vga_pattern_module on a 16x8 raster (8x4 active).
// Output at cycle c shows counter position p = c-2: h = p%16, v = (p/16)%8.
module tb_vga_pattern_module;

  localparam int DW = 8;
  localparam int PW = 12;
  localparam logic [23:0] FG    = 24'h123456;
  localparam logic [23:0] BLACK = 24'h000000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vga_pattern_module_if #(.D_WIDTH(DW), .P_WIDTH(PW)) bus();

  vga_pattern_module #(
    .D_WIDTH(DW), .P_WIDTH(PW),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CHECK_LOG2(1)
  ) dut (
    .VGA_CLK(clk),
    .VGA_RST(rst),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [23:0] exp_q[$];
  logic [23:0] rgb;

  assign rgb = {bus.VGA_R, bus.VGA_G, bus.VGA_B};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic set_colour(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.Red   = r;
    bus.Green = g;
    bus.Blue  = b;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    bus.RECT_X0 = PW'(x0);
    bus.RECT_X1 = PW'(x1);
    bus.RECT_Y0 = PW'(y0);
    bus.RECT_Y1 = PW'(y1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_de"}, 32'(bus.VGA_DE), 32'd0);
    chk({tag, "_hs"}, 32'(bus.VGA_HS), 32'd1);
    chk({tag, "_vs"}, 32'(bus.VGA_VS), 32'd0);
    chk({tag, "_fs"}, 32'(bus.FRAME_START), 32'd0);
    chk({tag, "_rgb"}, 32'(rgb), 32'(BLACK));
    chk({tag, "_fc"}, 32'(bus.FRAME_CNT), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h, v, p;
    logic exp_de, exp_hs, exp_vs, exp_fs;

    bus.MODE = 2'd0;
    set_colour(8'h12, 8'h34, 8'h56);
    set_rect(0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk_reset_outputs("in_reset");

    // Frame 0: solid, full timing; MODE flips to checker mid-frame.
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < 130; c++) begin
      if (c < 2) begin
        exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b0; exp_fs = 1'b0;
      end else begin
        p = c - 2;
        h = p % 16;
        v = (p / 16) % 8;
        exp_de = (h < 8) && (v < 4);
        exp_hs = !((h >= 10) && (h <= 12));
        exp_vs = (v == 5) || (v == 6);
        exp_fs = (h == 0) && (v == 0);
      end
      chk("f0_de", 32'(bus.VGA_DE), 32'(exp_de));
      chk("f0_hs", 32'(bus.VGA_HS), 32'(exp_hs));
      chk("f0_vs", 32'(bus.VGA_VS), 32'(exp_vs));
      chk("f0_fs", 32'(bus.FRAME_START), 32'(exp_fs));
      chk("f0_rgb", 32'(rgb), exp_de ? 32'(FG) : 32'(BLACK));
      chk("f0_fc", 32'(bus.FRAME_CNT), 32'd0);
      if (c == 50) bus.MODE = 2'd3;
      tick();
    end

    // Frame 1: checkerboard with 2-pixel squares.
    chk("f1_fs", 32'(bus.FRAME_START), 32'd1);
    chk("f1_fc", 32'(bus.FRAME_CNT), 32'd1);
    chk("chk_0_0", 32'(rgb), 32'(FG));
    goto_cyc(132);
    chk("chk_2_0_de", 32'(bus.VGA_DE), 32'd1);
    chk("chk_2_0", 32'(rgb), 32'(BLACK));
    goto_cyc(162);
    chk("chk_0_2", 32'(rgb), 32'(BLACK));
    goto_cyc(164);
    chk("chk_2_2", 32'(rgb), 32'(FG));
    goto_cyc(170);
    bus.MODE = 2'd1;
    set_rect(2, 5, 1, 3);
    goto_cyc(180);
    chk("chk_2_3_held", 32'(rgb), 32'(FG));

    // Frame 2: rectangle [2,5)x[1,3); empty rectangle queued for frame 3.
    goto_cyc(258);
    for (int c = 258; c < 386; c++) begin
      p = c - 258;
      h = p % 16;
      v = p / 16;
      exp_de = (h < 8) && (v < 4);
      chk("rect_de", 32'(bus.VGA_DE), 32'(exp_de));
      chk("rect_rgb", 32'(rgb),
          (exp_de && h >= 2 && h < 5 && v >= 1 && v < 3) ? 32'(FG) : 32'(BLACK));
      if (p == 0) chk("f2_fc", 32'(bus.FRAME_CNT), 32'd2);
      if (c == 300) set_rect(3, 3, 1, 3);
      tick();
    end

    // Frame 3: X0 == X1 gives an all-black frame; bars queued for frame 4.
    for (int c = 386; c < 514; c++) begin
      p = c - 386;
      h = p % 16;
      v = p / 16;
      chk("empty_de", 32'(bus.VGA_DE), 32'((h < 8) && (v < 4)));
      chk("empty_rgb", 32'(rgb), 32'(BLACK));
      if (c == 420) bus.MODE = 2'd2;
      tick();
    end

    // Frame 4: colour bars, one pixel wide, on lines 0 and 3.
    for (int line = 0; line < 4; line += 3) begin
      exp_q.push_back(24'hFFFFFF);
      exp_q.push_back(24'hFFFF00);
      exp_q.push_back(24'hFF00FF);
      exp_q.push_back(24'hFF0000);
      exp_q.push_back(24'h00FFFF);
      exp_q.push_back(24'h00FF00);
      exp_q.push_back(24'h0000FF);
      exp_q.push_back(24'h000000);
      goto_cyc(514 + line * 16);
      for (int i = 0; i < 8; i++) begin
        chk("bars_rgb", 32'(rgb), 32'(exp_q.pop_front()));
        tick();
      end
    end

    // Frame 5: one-cycle reset pulse in the middle of line 2.
    goto_cyc(674);
    chk("f5_fc", 32'(bus.FRAME_CNT), 32'd5);
    chk("f5_de_mid", 32'(bus.VGA_DE), 32'd1);
    goto_cyc(675);
    rst = 1'b1;
    tick();
    chk_reset_outputs("pulse");
    rst = 1'b0;
    cyc = 0;
    chk("rst_c0_de", 32'(bus.VGA_DE), 32'd0);
    tick();
    chk("rst_c1_de", 32'(bus.VGA_DE), 32'd0);
    chk("rst_c1_fs", 32'(bus.FRAME_START), 32'd0);
    tick();
    chk("rst_c2_de", 32'(bus.VGA_DE), 32'd1);
    chk("rst_c2_fs", 32'(bus.FRAME_START), 32'd1);
    chk("rst_c2_fc", 32'(bus.FRAME_CNT), 32'd0);
    chk("rst_c2_rgb", 32'(rgb), 32'hFFFFFF);
    goto_cyc(130);
    chk("rst_f1_fs", 32'(bus.FRAME_START), 32'd1);
    chk("rst_f1_fc", 32'(bus.FRAME_CNT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_module.md
# vga_pattern_module

Parametrised VGA raster generator: the next generation of the fixed-timing solid-colour display block. It produces sync, data-enable and RGB for any timing set from parameters, and selects one of four per-frame patterns: solid, rectangle, colour bars or checkerboard. Configuration is shadowed at frame boundaries so a frame never tears. It sits between the bus-side register/BRAM logic and the VGA pins, and replaces the separate sync and control pair.

## Interface
- D_WIDTH, 8, bits per colour channel
- P_WIDTH, 12, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal pixels (H_TOTAL = sum)
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical lines (V_TOTAL = sum)
- HS_POL, 0 / VS_POL, 0: asserted level of VGA_HS / VGA_VS
- CHECK_LOG2, 5: log2 of checkerboard square size in pixels
- VGA_CLK  in  1  pixel clock; all logic on rising edge
- VGA_RST  in  1  synchronous, active-high reset
- MODE  in  2  0 solid, 1 rectangle, 2 colour bars, 3 checkerboard
- Red, Green, Blue  in  D_WIDTH each  foreground colour
- RECT_X0, RECT_X1, RECT_Y0, RECT_Y1  in  P_WIDTH each  rectangle bounds, half-open [X0,X1) x [Y0,Y1)
- VGA_R, VGA_G, VGA_B  out  D_WIDTH each  pixel colour
- VGA_HS, VGA_VS  out  1  syncs
- VGA_DE  out  1  active-video indicator
- FRAME_START  out  1  one-cycle pulse aligned with output pixel (0,0)
- FRAME_CNT  out  8  completed-frame count, wraps 255->0

## Operation
- Stage 0 counters: H 0..H_TOTAL-1 increments every cycle; at wrap H->0 and V increments; V wraps V_TOTAL-1 -> 0.
- Active = H<H_ACTIVE && V<V_ACTIVE. HS asserted for H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS asserted for V in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines.
- Shadow regs (MODE, colours, rect bounds) load during reset and on the cycle with counters at (H_TOTAL-1, V_TOTAL-1). Input changes at any other time take effect from the next frame.
- Patterns (shadow values; black = all zeros):
  - mode 0: foreground on every active pixel.
  - mode 1: foreground inside the rectangle, black outside. X1<=X0 or Y1<=Y0 gives an all-black frame. Bounds beyond active are clipped naturally.
  - mode 2: bar b = min(H / (H_ACTIVE/8), 7); c = 7-b. R = all-ones if c[2], G if c[1], B if c[0]. White at left, black at right; the last bar absorbs the remainder.
  - mode 3: foreground where H[CHECK_LOG2] ^ V[CHECK_LOG2] = 0, else black.
- RGB forced to zero whenever VGA_DE=0.
- FRAME_CNT increments on each FRAME_START except the first after reset.

## Timing
- Latency 2 cycles: every output (HS, VS, DE, RGB, FRAME_START) reflects counter state from 2 cycles earlier. All outputs are registered and mutually aligned; no combinational input->output path.
- Reset values: counters (0,0); VGA_HS=~HS_POL, VGA_VS=~VS_POL; VGA_DE=0; RGB=0; FRAME_START=0; FRAME_CNT=0; pipeline regs cleared.
- Let cycle 0 be the first with VGA_RST low. Counter is (0,0) at cycle 0. VGA_DE and FRAME_START first go high at cycle 2.
- Reset asserted mid-frame: outputs take reset values on the next edge, and the raster restarts from (0,0) on release. No partial sync pulse is stretched.
- MODE change mid-frame: the current frame is unaffected.

## Structure
- The shared params include holds D_WIDTH/P_WIDTH defaults, mode encodings (MODE_SOLID, MODE_RECT, MODE_BARS, MODE_CHECK) and the default 640x480@60 timing constants.
- Sub-module vga_timing_gen holds the H/V counters, sync/active decode and frame-end strobe. The top holds the shadow regs, pattern mux and output pipeline.

## Test plan
Bench timing: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), CHECK_LOG2=1.
- Reset release, mode 0, colour (0x12,0x34,0x56):
  - First DE at cycle 2; DE high 8 of every 16 cycles on lines 0-3.
  - RGB=(0x12,0x34,0x56) while DE high, 0 otherwise.
  - FRAME_START every 128 cycles.
- Sync timing, HS_POL=0, VS_POL=1:
  - VGA_HS low exactly for H=10..12 of each line (output cycles 12..14 of each line from cycle 2).
  - VGA_VS high for lines 5-6 only.
- Mode 1, rect [2,5)x[1,3):
  - Foreground only at H 2-4 on V 1-2; all other active pixels black.
  - X0=X1=3 gives an all-black frame.
- Mode 2, bar width 1:
  - Pixels H0..H7 = white, yellow(R,G), magenta(R,B), red, cyan(G,B), green, blue, black.
- MODE switched 0->3 mid-frame:
  - Remainder of the frame stays solid.
  - Next frame is checkerboard: (0,0) foreground, (2,0) black, (0,2) black.
  - FRAME_CNT reads 1 on that frame.
- VGA_RST pulsed for 1 cycle mid-line 2:
  - Next cycle all outputs at reset values.
  - Raster restarts: DE high 2 cycles after release; FRAME_CNT 0.
